// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter/sequencer sharing one DLX memory between
// the instruction-fetch port (port 0, read-only) and the load/store port
// (port 1, read/write). Each transaction runs IDLE -> BUSY -> RELEASE, so the
// memory always sees an enable low cycle between transactions.
// Optional feature: define MEM_ARB_TIMEOUT_EN to bound the wait for
// mem_data_ready to TIMEOUT_CYCLES; an expired transaction completes with err=1.
module mem_arbiter #(
    parameter int ADDRESS_SIZE   = 16,
    parameter int WORD_SIZE      = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req0_valid,
    input  logic [ADDRESS_SIZE-1:0] req0_addr,
    output logic                    req0_done,
    output logic [WORD_SIZE-1:0]    req0_rdata,
    input  logic                    req1_valid,
    input  logic [ADDRESS_SIZE-1:0] req1_addr,
    input  logic                    req1_rnw,
    input  logic [WORD_SIZE-1:0]    req1_wdata,
    output logic                    req1_done,
    output logic [WORD_SIZE-1:0]    req1_rdata,
    output logic                    err,
    output logic [ADDRESS_SIZE-1:0] mem_address,
    output logic                    mem_enable,
    output logic                    mem_readnotwrite,
    output logic [WORD_SIZE-1:0]    mem_wdata,
    input  logic [WORD_SIZE-1:0]    mem_rdata,
    input  logic                    mem_data_ready
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 last_grant;  // port granted by the last completed transaction
    logic                 grant;       // port owning the transaction in flight
    logic                 pick;        // port chosen in IDLE
    logic                 start;
    logic                 finish;
    logic                 expire;
    logic [WORD_SIZE-1:0] rdata_in;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)  state_next = BUSY;
            BUSY:    if (finish) state_next = RELEASE;
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Arbitration and completion decode; on a tie the port not granted last wins
    always_comb begin
        pick     = req1_valid && (!req0_valid || !last_grant);
        start    = (state == IDLE) && (req0_valid || req1_valid);
        finish   = (state == BUSY) && (mem_data_ready || expire);
        rdata_in = expire ? '0 : mem_rdata;
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] timeout_cnt;

    // Count BUSY cycles spent waiting for data-ready; cleared when a grant starts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_cnt <= '0;
        end else if (start) begin
            timeout_cnt <= '0;
        end else if ((state == BUSY) && !mem_data_ready) begin
            timeout_cnt <= timeout_cnt + CNT_W'(1);
        end
    end

    // Expiry fires on the cycle whose increment reaches TIMEOUT_CYCLES; data-ready wins
    assign expire = (state == BUSY) && !mem_data_ready &&
                    (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Error flag accompanies the done pulse of an expired transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= expire;
        end
    end
`else
    // Without the timeout feature BUSY waits indefinitely: expiry is constant false
    assign expire = (TIMEOUT_CYCLES < 0);
    assign err    = 1'b0;
`endif

    // Memory-side registers, done pulses, read data and round-robin history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_address      <= '0;
            mem_enable       <= 1'b0;
            mem_readnotwrite <= 1'b0;
            mem_wdata        <= '0;
            req0_done        <= 1'b0;
            req1_done        <= 1'b0;
            req0_rdata       <= '0;
            req1_rdata       <= '0;
            last_grant       <= 1'b1;
            grant            <= 1'b0;
        end else begin
            req0_done <= 1'b0;
            req1_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        grant      <= pick;
                        mem_enable <= 1'b1;
                        if (pick) begin
                            mem_address      <= req1_addr;
                            mem_readnotwrite <= req1_rnw;
                            mem_wdata        <= req1_wdata;
                        end else begin
                            mem_address      <= req0_addr;
                            mem_readnotwrite <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (finish) begin
                        mem_enable <= 1'b0;
                        last_grant <= grant;
                        if (grant) begin
                            req1_done <= 1'b1;
                            if (mem_readnotwrite) begin
                                req1_rdata <= rdata_in;
                            end
                        end else begin
                            req0_done  <= 1'b1;
                            req0_rdata <= rdata_in;
                        end
                    end
                end
                default: begin
                    mem_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter. Stimulus pushes the
// expected completion (port, read data, err) into a queue; a monitor pops and
// compares on every done pulse. A small memory model answers reads with
// 0xDEADBEEF at 0x0010 and {16'hA5A5, address} elsewhere.
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int WW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid;
    logic [AW-1:0] req0_addr;
    logic          req0_done;
    logic [WW-1:0] req0_rdata;
    logic          req1_valid;
    logic [AW-1:0] req1_addr;
    logic          req1_rnw;
    logic [WW-1:0] req1_wdata;
    logic          req1_done;
    logic [WW-1:0] req1_rdata;
    logic          err;
    logic [AW-1:0] mem_address;
    logic          mem_enable;
    logic          mem_readnotwrite;
    logic [WW-1:0] mem_wdata;
    logic [WW-1:0] mem_rdata;
    logic          mem_data_ready;

    mem_arbiter #(
        .ADDRESS_SIZE  (AW),
        .WORD_SIZE     (WW),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req0_valid      (req0_valid),
        .req0_addr       (req0_addr),
        .req0_done       (req0_done),
        .req0_rdata      (req0_rdata),
        .req1_valid      (req1_valid),
        .req1_addr       (req1_addr),
        .req1_rnw        (req1_rnw),
        .req1_wdata      (req1_wdata),
        .req1_done       (req1_done),
        .req1_rdata      (req1_rdata),
        .err             (err),
        .mem_address     (mem_address),
        .mem_enable      (mem_enable),
        .mem_readnotwrite(mem_readnotwrite),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_data_ready  (mem_data_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            port;
        logic [WW-1:0] rdata;
        bit            err;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   done_cnt = 0;
    int   en_run = 0;
    int   last_en_len = 0;
    int   cyc = 0;
    int   last_rise = -1;
    int   lat = 1;
    int   en_cnt = 0;
    bit   always_rdy = 1'b0;
    bit   rate_chk = 1'b0;
    bit   prev_en = 1'b0;

    function automatic logic [WW-1:0] rdata_for(input logic [AW-1:0] a);
        return (a == 16'h0010) ? 32'hDEADBEEF : {16'hA5A5, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_en();
        int n = 0;
        while (!mem_enable && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!mem_enable) begin
            checks++;
            errors++;
            $display("FAIL wait_enable: got enable 0 expected 1 within 50 cycles");
        end
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (done_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL wait_done: got %0d done pulses expected %0d", done_cnt, target);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: data-ready after 'lat' extra enable cycles, or always high
    initial begin
        mem_data_ready = 1'b0;
        mem_rdata      = '0;
        forever begin
            @(negedge clk);
            mem_rdata = rdata_for(mem_address);
            if (mem_enable) en_cnt++;
            else            en_cnt = 0;
            mem_data_ready = always_rdy || (mem_enable && en_cnt == lat + 1);
        end
    end

    // Monitor: enable run length, enable period, scoreboard on done pulses
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_enable) begin
                en_run++;
            end else begin
                if (en_run != 0) last_en_len = en_run;
                en_run = 0;
            end
            if (rate_chk && mem_enable && !prev_en) begin
                if (last_rise >= 0) check("enable_period", 32'(cyc - last_rise), 32'd3);
                last_rise = cyc;
            end
            prev_en = mem_enable;
            if (req0_done && req1_done) begin
                checks++;
                errors++;
                $display("FAIL both_done: got both ports done expected one");
            end
            if (req0_done || req1_done) begin
                done_cnt++;
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done on port %0d expected none", req1_done);
                end else begin
                    e = sbq.pop_front();
                    check("done_port", 32'(req1_done), 32'(e.port));
                    check("done_rdata", e.port ? req1_rdata : req0_rdata, e.rdata);
                    check("done_err", 32'(err), 32'(e.err));
                end
            end else if (err) begin
                checks++;
                errors++;
                $display("FAIL err_without_done: got err 1 expected 0");
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        rst        = 1'b1;
        req0_valid = 1'b0;
        req0_addr  = '0;
        req1_valid = 1'b0;
        req1_addr  = '0;
        req1_rnw   = 1'b1;
        req1_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_enable",  32'(mem_enable), 32'd0);
        check("rst_address", 32'(mem_address), 32'd0);
        check("rst_rnw",     32'(mem_readnotwrite), 32'd0);
        check("rst_wdata",   mem_wdata, 32'd0);
        check("rst_done0",   32'(req0_done), 32'd0);
        check("rst_done1",   32'(req1_done), 32'd0);
        check("rst_err",     32'(err), 32'd0);
        check("rst_rdata0",  req0_rdata, 32'd0);
        check("rst_rdata1",  req1_rdata, 32'd0);
        rst = 1'b0;

        // Port 0 read at 0x0010, data-ready one cycle after enable
        req0_addr  = 16'h0010;
        req0_valid = 1'b1;
        sbq.push_back('{1'b0, 32'hDEADBEEF, 1'b0});
        wait_en();
        check("rd0_address", 32'(mem_address), 32'h0010);
        check("rd0_rnw",     32'(mem_readnotwrite), 32'd1);
        wait_done(1);
        req0_valid = 1'b0;
        check("rd0_en_len",  32'(last_en_len), 32'd2);
        check("rd0_en_low",  32'(mem_enable), 32'd0);
        @(negedge clk);

        // Port 1 write: rdata must keep its previous value (0)
        req1_addr  = 16'h0200;
        req1_rnw   = 1'b0;
        req1_wdata = 32'h12345678;
        req1_valid = 1'b1;
        sbq.push_back('{1'b1, 32'h0, 1'b0});
        wait_en();
        check("wr1_address", 32'(mem_address), 32'h0200);
        check("wr1_rnw",     32'(mem_readnotwrite), 32'd0);
        check("wr1_wdata",   mem_wdata, 32'h12345678);
        wait_done(2);
        req1_valid = 1'b0;
        check("wr1_en_len",  32'(last_en_len), 32'd2);
        @(negedge clk);

        // Port 1 read at 0x0300
        req1_addr  = 16'h0300;
        req1_rnw   = 1'b1;
        req1_valid = 1'b1;
        sbq.push_back('{1'b1, 32'hA5A50300, 1'b0});
        wait_done(3);
        req1_valid = 1'b0;
        @(negedge clk);

        // Both ports continuously valid, data-ready always high: 0,1,0,1
        always_rdy = 1'b1;
        rate_chk   = 1'b1;
        req0_addr  = 16'h0040;
        req1_addr  = 16'h0080;
        req1_rnw   = 1'b1;
        sbq.push_back('{1'b0, 32'hA5A50040, 1'b0});
        sbq.push_back('{1'b1, 32'hA5A50080, 1'b0});
        sbq.push_back('{1'b0, 32'hA5A50040, 1'b0});
        sbq.push_back('{1'b1, 32'hA5A50080, 1'b0});
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        wait_done(7);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rate_chk   = 1'b0;
        always_rdy = 1'b0;
        repeat (2) @(negedge clk);

        // Reset asserted during BUSY aborts the transaction without a done
        lat        = 1000;
        req0_addr  = 16'h0050;
        req0_valid = 1'b1;
        wait_en();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_enable",  32'(mem_enable), 32'd0);
        check("abort_address", 32'(mem_address), 32'd0);
        check("abort_rnw",     32'(mem_readnotwrite), 32'd0);
        check("abort_rdata0",  req0_rdata, 32'd0);
        check("abort_rdata1",  req1_rdata, 32'd0);
        req0_valid = 1'b0;
        d = done_cnt;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        lat = 1;
        repeat (4) @(negedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt), 32'(d));

        // Port 0 read after reset release completes normally
        req0_addr  = 16'h0010;
        req0_valid = 1'b1;
        sbq.push_back('{1'b0, 32'hDEADBEEF, 1'b0});
        wait_done(d + 1);
        req0_valid = 1'b0;
        check("post_rst_en_len", 32'(last_en_len), 32'd2);
        @(negedge clk);

`ifdef MEM_ARB_TIMEOUT_EN
        // Data-ready never arrives: done and err after 4 BUSY cycles, rdata 0
        lat        = 1000;
        req0_addr  = 16'h0020;
        req0_valid = 1'b1;
        sbq.push_back('{1'b0, 32'h0, 1'b1});
        wait_done(d + 2);
        req0_valid = 1'b0;
        check("tmo_en_len", 32'(last_en_len), 32'd4);
        @(negedge clk);

        // Data-ready on the 4th BUSY cycle wins over expiry
        lat        = 3;
        req0_valid = 1'b1;
        sbq.push_back('{1'b0, 32'hA5A50020, 1'b0});
        wait_done(d + 3);
        req0_valid = 1'b0;
        check("tmo_ready_en_len", 32'(last_en_len), 32'd4);
        @(negedge clk);
`endif

        @(negedge clk);
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer that shares one read/write DLX memory between the instruction-fetch unit (port 0, read-only) and the load/store unit (port 1, read/write). It sits between the core and the memory model or RAM, and drives the memory's address, enable and read-not-write lines. It completes each transaction on the memory's data-ready handshake and returns read data and a one-cycle done pulse to the granted requester. Grants are round-robin, so neither requester starves.

## Interface
Parameters:
- ADDRESS_SIZE, 16, memory address width
- WORD_SIZE, 32, data word width
- TIMEOUT_CYCLES, 64, maximum cycles to wait for data-ready (used only with timeout enabled)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- req0_valid  input  1  fetch request, held until req0_done
- req0_addr  input  ADDRESS_SIZE  fetch address, stable while valid
- req0_done  output  1  one-cycle completion pulse for port 0
- req0_rdata  output  WORD_SIZE  fetched word, valid with req0_done
- req1_valid  input  1  data request, held until req1_done
- req1_addr  input  ADDRESS_SIZE  data address
- req1_rnw  input  1  1 = read, 0 = write
- req1_wdata  input  WORD_SIZE  write data
- req1_done  output  1  one-cycle completion pulse for port 1
- req1_rdata  output  WORD_SIZE  load data, valid with req1_done on reads
- err  output  1  one-cycle pulse with a done pulse that ended by timeout
- mem_address  output  ADDRESS_SIZE  memory address
- mem_enable  output  1  memory enable, high for the whole transaction
- mem_readnotwrite  output  1  memory direction
- mem_wdata  output  WORD_SIZE  write data; the top level drives it onto the inout data bus when enable=1 and readnotwrite=0
- mem_rdata  input  WORD_SIZE  data sampled from the memory data bus
- mem_data_ready  input  1  memory completion

## Operation
- FSM states: IDLE, BUSY, RELEASE.
- IDLE: if any valid is sampled high, register the granted port's address, direction and wdata into the mem_* outputs, set mem_enable=1, and go to BUSY.
- Port 0 transactions are always reads (mem_readnotwrite=1).
- Arbitration: with one request, grant it. With both, grant the port not granted last. The last_grant register resets to 1, so port 0 wins the first tie.
- BUSY: hold all mem_* outputs stable.
- BUSY, mem_data_ready sampled high:
  - register mem_rdata into the granted port's rdata on reads only; rdata holds its value on writes
  - pulse that port's done for one cycle
  - update last_grant
  - drop mem_enable, go to RELEASE
- RELEASE: mem_enable=0 for exactly one cycle, then IDLE. This guarantees an enable low edge between transactions.
- A requester dropping valid mid-transaction is illegal. The transaction still completes and done still pulses.
- The non-granted request stays pending and is granted at the next IDLE.
- rdata outputs hold their value until the next read completion on that port.

## Timing
- Reset values: all outputs 0, last_grant=1, timeout counter 0, state IDLE.
- Reset asserted mid-transaction aborts it immediately. No done pulse is issued, and requesters re-issue after reset.
- Request latency: valid sampled at edge N gives mem_enable=1 after edge N.
- Completion: mem_data_ready sampled at edge M gives done and rdata valid in the cycle after M, with mem_enable=0 in that same cycle (RELEASE).
- Best-case throughput: one transaction per 3 cycles (IDLE, BUSY, RELEASE) when data-ready arrives on the first BUSY cycle.
- mem_data_ready is ignored outside BUSY.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - a counter of width $clog2(TIMEOUT_CYCLES+1) clears on entering BUSY and increments each BUSY cycle without data-ready
  - at count TIMEOUT_CYCLES, the granted done pulses together with err=1, rdata is written to 0 (reads), and the FSM goes to RELEASE
  - data-ready in the same cycle as expiry wins: normal completion, err=0
- MEM_ARB_TIMEOUT_EN undefined: BUSY waits indefinitely, err is tied to 0, and no counter is built.

## Test plan
- Reset, then port 0 read at 0x0010, memory returns 0xDEADBEEF with data-ready one cycle after enable -> req0_done pulses once with req0_rdata=0xDEADBEEF; mem_enable high exactly 2 cycles.
- Port 1 write of 0x12345678 to 0x0200 -> mem_readnotwrite=0, mem_wdata=0x12345678 during BUSY; req1_done pulses; req1_rdata unchanged.
- Both ports valid continuously, ready always 1 -> grants alternate 0,1,0,1 starting with port 0; a new enable every 3 cycles.
- rst asserted during BUSY -> all outputs 0 asynchronously, no done pulse; port 0 request after release completes normally.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, data-ready never asserted -> done and err pulse together after 4 BUSY cycles, rdata=0; with data-ready on the 4th cycle -> err=0.
